// File: rtl/bip_pkg.sv
// Shared BIP definitions: bus widths, HALT opcode and the execution-controller state encoding.
// Also imported by the Control block.
package bip_pkg;

  localparam int ADDR_W   = 11;
  localparam int DATA_W   = 16;
  localparam int OPCODE_W = 5;

  localparam logic [OPCODE_W-1:0] HALT_OP = 5'b00000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_PAUSE  = 3'd3,
    ST_STEP   = 3'd4,
    ST_HALTED = 3'd5
  } state_e;

  // States in which the CPU is frozen and the host may own the data RAM.
  function automatic logic is_stopped(state_e s);
    return (s == ST_IDLE) || (s == ST_PAUSE) || (s == ST_HALTED);
  endfunction

endpackage

// File: rtl/bip_exec_ctrl_if.sv
// Host/debug access port to the BIP data RAM: level request, one-cycle ack.
interface bip_exec_ctrl_if #(
  parameter int ADDR_W = bip_pkg::ADDR_W,
  parameter int DATA_W = bip_pkg::DATA_W
);
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_ack;

  modport master (output host_req, host_we, host_addr, host_wdata, input host_ack);
  modport slave  (input host_req, host_we, host_addr, host_wdata, output host_ack);
endinterface

// File: rtl/bip_ram_arb.sv
// Data-RAM port mux between the running CPU and the host port, plus the host grant/ack register.
module bip_ram_arb #(
  parameter int ADDR_W = bip_pkg::ADDR_W,
  parameter int DATA_W = bip_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              allow_i,
  input  logic              cpu_en_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  input  logic              cpu_wr_i,
  input  logic              cpu_rd_i,
  bip_exec_ctrl_if.slave    host,
  output logic              grant_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  output logic              ram_we_o,
  output logic              ram_re_o
);

  logic ack_q;
  logic grant;

  // The ack cycle still sees host_req high, so it must not re-grant.
  assign grant         = allow_i & ~rst & host.host_req & ~ack_q;
  assign grant_o       = grant;
  assign host.host_ack = ack_q;

  always_ff @(posedge clk) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= grant;
  end

  always_comb begin
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    ram_we_o    = 1'b0;
    ram_re_o    = 1'b0;
    if (cpu_en_i) begin
      ram_addr_o  = cpu_addr_i;
      ram_wdata_o = cpu_wdata_i;
      ram_we_o    = cpu_wr_i;
      ram_re_o    = cpu_rd_i;
    end else if (grant) begin
      ram_addr_o  = host.host_addr;
      ram_wdata_o = host.host_wdata;
      ram_we_o    = host.host_we;
      ram_re_o    = ~host.host_we;
    end
  end

endmodule

// File: rtl/bip_exec_ctrl.sv
// Run/step/halt sequencer for the BIP core: drives Control's enable/reset, counts executed
// cycles, stops on HALT and hands the data RAM to the host while the CPU is stopped.
module bip_exec_ctrl #(
  parameter int                   ADDR_W   = bip_pkg::ADDR_W,
  parameter int                   DATA_W   = bip_pkg::DATA_W,
  parameter int                   OPCODE_W = bip_pkg::OPCODE_W,
  parameter int                   CNT_W    = 32,
  parameter logic [OPCODE_W-1:0]  HALT_OP  = bip_pkg::HALT_OP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                step,
  input  logic                pause,
  input  logic [OPCODE_W-1:0] opcode,
  output logic                cpu_en,
  output logic                cpu_rst,
  output logic                halted,
  output logic [CNT_W-1:0]    cycle_cnt,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  input  logic                cpu_wr,
  input  logic                cpu_rd,
  bip_exec_ctrl_if.slave      host,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_wdata,
  output logic                ram_we,
  output logic                ram_re
);
  import bip_pkg::*;

  state_e           state_q, state_d;
  logic             step_mode_q, step_mode_d;
  logic             pend_start_q, pend_step_q;
  logic             cpu_en_q, cpu_rst_q, halted_q;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             grant, start_eff, step_eff, is_halt;

  assign is_halt   = (opcode == HALT_OP);
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
  // A start/step seen in a host grant cycle is replayed during the ack cycle.
  assign start_eff = (start | pend_start_q) & ~grant;
  assign step_eff  = (step  | pend_step_q)  & ~grant;

  // NOTE: next-state logic assigns defaults first so every path is covered and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    step_mode_d = step_mode_q;
    cnt_d       = cnt_q;
    unique case (state_q)
      ST_IDLE, ST_HALTED: begin
        if (start_eff) begin
          state_d     = ST_CLEAR;
          step_mode_d = 1'b0;
        end else if (step_eff) begin
          state_d     = ST_CLEAR;
          step_mode_d = 1'b1;
        end
      end
      ST_CLEAR: begin
        cnt_d   = '0;
        state_d = step_mode_q ? ST_PAUSE : ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        if (is_halt)    state_d = ST_HALTED;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (start_eff)     state_d = ST_RUN;
        else if (step_eff) state_d = ST_STEP;
      end
      ST_STEP: begin
        cnt_d   = cnt_inc;
        state_d = is_halt ? ST_HALTED : ST_PAUSE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      step_mode_q  <= 1'b0;
      pend_start_q <= 1'b0;
      pend_step_q  <= 1'b0;
      cnt_q        <= '0;
      cpu_en_q     <= 1'b0;
      cpu_rst_q    <= 1'b1;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_mode_q  <= step_mode_d;
      pend_start_q <= grant & start;
      pend_step_q  <= grant & step;
      cnt_q        <= cnt_d;
      cpu_en_q     <= (state_d == ST_RUN) || (state_d == ST_STEP);
      cpu_rst_q    <= (state_d == ST_IDLE) || (state_d == ST_CLEAR);
      halted_q     <= (state_d == ST_HALTED);
    end
  end

  assign cpu_en    = cpu_en_q;
  assign cpu_rst   = cpu_rst_q;
  assign halted    = halted_q;
  assign cycle_cnt = cnt_q;

  bip_ram_arb #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .allow_i     (is_stopped(state_q)),
    .cpu_en_i    (cpu_en_q),
    .cpu_addr_i  (cpu_addr),
    .cpu_wdata_i (cpu_wdata),
    .cpu_wr_i    (cpu_wr),
    .cpu_rd_i    (cpu_rd),
    .host        (host),
    .grant_o     (grant),
    .ram_addr_o  (ram_addr),
    .ram_wdata_o (ram_wdata),
    .ram_we_o    (ram_we),
    .ram_re_o    (ram_re)
  );

endmodule
